// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / divide / remainder unit: 32-cycle shift-add multiply and restoring divide.
// Build option MULDIV_FAST_MUL_EN replaces the shift-add multiply with a single-cycle combinational product.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] instructions,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    input  logic        start,
    output logic [63:0] ALUoutput,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_REM} op_t;

    state_t      state;
    op_t         op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] acc;
    logic [5:0]  count;

    logic [2:0]  sel;
    logic        sel_valid;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic        unused_ok;

    assign sel       = instructions[12:10];
    assign sel_valid = (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);

    // acc holds {partial product, remaining multiplier} for mul and {remainder, quotient/dividend} for div
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? op_a : 32'd0)};
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, op_b};
        div_ge    = (div_shift >= {1'b0, op_b});
    end

    assign unused_ok = ^{instructions[9:0], div_diff[32], mul_sum};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_MUL;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            count     <= '0;
            ALUoutput <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && sel_valid) begin
                        op_a  <= v1;
                        op_b  <= v2;
                        count <= '0;
                        busy  <= 1'b1;
                        if (sel[0]) begin
                            op    <= OP_MUL;
                            acc   <= {32'd0, v2};
                            state <= MUL;
                        end else begin
                            op    <= sel[1] ? OP_DIV : OP_REM;
                            acc   <= {32'd0, v1};
                            state <= DIV;
                        end
                    end
                end

                MUL: begin
                    if (count == 6'd32) begin
                        ALUoutput <= acc;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= FIN;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        acc   <= {32'd0, op_a} * {32'd0, op_b};
                        count <= 6'd32;
`else
                        acc   <= {mul_sum, acc[31:1]};
                        count <= count + 6'd1;
`endif
                    end
                end

                DIV: begin
                    if (op_b == 32'd0) begin
                        ALUoutput <= (op == OP_REM) ? {32'hFFFF_FFFF, op_a}
                                                    : {op_a, 32'hFFFF_FFFF};
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= FIN;
                    end else if (count == 6'd32) begin
                        ALUoutput <= (op == OP_REM) ? {acc[31:0], acc[63:32]} : acc;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= FIN;
                    end else begin
                        if (div_ge)
                            acc <= {div_diff[31:0], acc[30:0], 1'b1};
                        else
                            acc <= {div_shift[31:0], acc[30:0], 1'b0};
                        count <= count + 6'd1;
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a negedge monitor pops on done.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] instructions = '0;
    logic [31:0] v1 = '0;
    logic [31:0] v2 = '0;
    logic        start = 1'b0;
    logic [63:0] ALUoutput;
    logic        busy;
    logic        done;

    muldiv_unit dut (
        .clk          (clk),
        .rst          (rst),
        .instructions (instructions),
        .v1           (v1),
        .v2           (v2),
        .start        (start),
        .ALUoutput    (ALUoutput),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] last_out = '0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif

    localparam logic [12:0] I_MUL = 13'h0400;
    localparam logic [12:0] I_DIV = 13'h0800;
    localparam logic [12:0] I_REM = 13'h1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic; latency counted in edges from sampling edge to done-setting edge
    function automatic exp_t model(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.start_cyc = 0;
        if (s == 3'b001) begin
            e.res = 64'(a) * 64'(b);
            e.lat = MUL_LAT;
        end else if (b == 0) begin
            e.res = (s == 3'b100) ? {32'hFFFF_FFFF, a} : {a, 32'hFFFF_FFFF};
            e.lat = 1;
        end else begin
            e.res = (s == 3'b100) ? {a / b, a % b} : {a % b, a / b};
            e.lat = 33;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 64'(busy), 64'((sb.size() != 0) && !done));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", ALUoutput, e.res);
                    chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
                    last_out = e.res;
                end
            end else begin
                chk("hold", ALUoutput, last_out);
            end
        end
    end

    // Drive at posedge+2; the request is sampled on the next edge
    task automatic issue(input logic [12:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input bit accept);
        exp_t e;
        logic [9:0] noise;
        noise        = 10'($urandom);
        instructions = {ins[12:10], noise};
        v1           = a;
        v2           = b;
        start        = 1'b1;
        e            = model(ins[12:10], a, b);
        e.start_cyc  = cyc + 1;
        @(posedge clk);
        if (accept) sb.push_back(e);
        #2;
        start        = 1'b0;
        v1           = $urandom;
        v2           = $urandom;
        instructions = 13'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (sb.size() != 0) begin
            chk("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_out", ALUoutput, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        mon_en = 1'b1;

        issue(I_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_idle();
        issue(I_DIV, 32'd100, 32'd7, 1'b1);               wait_idle();
        issue(I_REM, 32'd100, 32'd7, 1'b1);               wait_idle();
        issue(I_DIV, 32'd55, 32'd0, 1'b1);                wait_idle();
        issue(I_REM, 32'd55, 32'd0, 1'b1);                wait_idle();
        issue(I_MUL, 32'd0, 32'h1234_5678, 1'b1);         wait_idle();

        // Second start at N+10 lands while busy (iterative build) and is ignored
        issue(I_MUL, 32'd3, 32'd5, 1'b1);
        repeat (9) begin @(posedge clk); #2; end
`ifdef MULDIV_FAST_MUL_EN
        issue(I_DIV, 32'd77, 32'd3, 1'b1);
`else
        issue(I_DIV, 32'd77, 32'd3, 1'b0);
`endif
        wait_idle();

        // Reset mid-divide aborts with no done
        issue(I_DIV, 32'd1000, 32'd3, 1'b1);
        repeat (11) begin @(posedge clk); #2; end
        rst = 1'b1;
        sb.delete();
        last_out = '0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out", ALUoutput, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        issue(I_REM, 32'd1000, 32'd3, 1'b1); wait_idle();

        // Two op bits set: ignored
        issue(13'h0C00, 32'd9, 32'd4, 1'b0);
        repeat (4) begin @(posedge clk); #2; end

        // Start during the done cycle (FIN) is ignored
        issue(I_DIV, 32'd100, 32'd7, 1'b1);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #2;
            if (done) break;
        end
        issue(I_MUL, 32'd9, 32'd9, 1'b0);
        repeat (3) begin @(posedge clk); #2; end

        for (int i = 0; i < 40; i++) begin
            logic [12:0] ins;
            logic [31:0] a;
            logic [31:0] b;
            int          r;
            r   = $urandom_range(0, 2);
            ins = (r == 0) ? I_MUL : (r == 1) ? I_DIV : I_REM;
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            issue(ins, a, b, 1'b1);
            wait_idle();
        end

        repeat (3) begin @(posedge clk); #2; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 instructions  input  13  one-hot ALU op bus; bit10 = mul, bit11 = div, bit12 = rem; other bits are ignored by this block.
REQ-004 v1  input  32  operand A (dividend / multiplicand), unsigned.
REQ-005 v2  input  32  operand B (divisor / multiplier), unsigned.
REQ-006 start  input  1  request strobe, one cycle, sampled only in IDLE.
REQ-007 ALUoutput  output  64  result register, held until the next accepted start.
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 done  output  1  one-cycle pulse when ALUoutput is valid.

Function
REQ-010 FSM states SHALL be IDLE, MUL, DIV, FIN; encoding is free.
REQ-011 IDLE and start with exactly one of instructions[12:10] set SHALL latch v1, v2 and the op, clear the 6-bit iteration counter, set busy, and go to MUL (bit10) or DIV (bit11/bit12).
REQ-012 start with zero or multiple bits of [12:10] set SHALL be ignored; stay IDLE, no done.
REQ-013 start while busy SHALL be ignored; latched operands SHALL NOT change mid-operation.
REQ-014 MUL SHALL run a shift-add loop, one multiplier bit per cycle, for 32 cycles, giving a 64-bit unsigned product.
REQ-015 DIV SHALL run a restoring divide, one quotient bit per cycle, for 32 cycles, giving a 32-bit quotient Q and a 32-bit remainder R.
REQ-016 After the last iteration the FSM SHALL enter FIN for one cycle: ALUoutput updated, done = 1, busy = 0. It then returns to IDLE.
REQ-017 Latency SHALL be as follows: start sampled at edge N; busy high N+1..N+33; done high in cycle N+34 (iterative path).
REQ-018 Result layout: mul -> {P[63:32], P[31:0]}; div -> {R, Q}; rem -> {Q, R}. Bits [31:0] always carry the architectural result.
REQ-019 Divide by zero (v2 == 0 at start) SHALL skip iteration: ALUoutput = div {v1, 32'hFFFFFFFF} / rem {32'hFFFFFFFF, v1}; done in cycle N+2.
REQ-020 A mul with either operand zero SHALL still take the full path latency and produce 0.
REQ-021 Sign handling is out of scope; operands are unsigned magnitudes supplied by the control stage.
REQ-022 A start accepted in the same cycle that done is high SHALL NOT occur (FSM is in FIN, not IDLE); the start is ignored.
REQ-023 ALUoutput SHALL NOT change outside FIN.

Reset
REQ-024 rst SHALL immediately force IDLE, busy = 0, done = 0, ALUoutput = 0, counter = 0, and clear the latched operands.
REQ-025 rst asserted mid-operation SHALL abort the operation with no done pulse. The first start after release is accepted normally.

Configuration
REQ-026 Macro MULDIV_FAST_MUL_EN:
- When defined, MUL SHALL compute the product combinationally from the latched operands in a single MUL cycle, so done occurs in cycle N+3.
- When undefined, the 32-cycle shift-add path of REQ-014 and REQ-017 SHALL be used.
- DIV timing and all other behaviour SHALL be identical in both builds.

Verification
REQ-027 mul, v1 = 32'hFFFFFFFF, v2 = 32'hFFFFFFFF -> ALUoutput = 64'hFFFFFFFE00000001; done at N+34 (N+3 with MULDIV_FAST_MUL_EN).
REQ-028 div, v1 = 100, v2 = 7 -> ALUoutput[31:0] = 14, [63:32] = 2; rem with the same operands -> [31:0] = 2, [63:32] = 14.
REQ-029 div, v1 = 55, v2 = 0 -> [31:0] = 32'hFFFFFFFF, [63:32] = 55, done at N+2; rem -> [31:0] = 55.
REQ-030 start mul 3*5, second start with div at N+10 -> second start ignored; single done with product 15.
REQ-031 rst pulsed at N+12 during div -> busy = 0 and ALUoutput = 0 immediately, no done; next start completes correctly.
REQ-032 start with instructions = 13'h0C00 (two bits set) -> busy stays 0, no done, ALUoutput unchanged.
